// File: rtl/traffic_gen_pkg.sv
// Shared definitions for the traffic generator: FSM states, destination
// mode encodings and the LFSR feedback polynomials.
package traffic_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_FIXED     = 2'd0;
    localparam logic [1:0] MODE_RR        = 2'd1;
    localparam logic [1:0] MODE_RAND      = 2'd2;
    localparam logic [1:0] MODE_FIXED_ALT = 2'd3;

    // Right-shift Galois feedback masks for maximal-length sequences.
    // Unlisted widths fall back to a simple non-zero mask.
    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] taps;
        case (width)
            3:       taps = 64'h6;
            4:       taps = 64'hC;
            5:       taps = 64'h14;
            6:       taps = 64'h30;
            7:       taps = 64'h60;
            8:       taps = 64'hB8;
            16:      taps = 64'hB400;
            32:      taps = 64'h8020_0003;
            default: taps = (64'h1 << (width - 1)) | 64'h1;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_en.sv
// Galois LFSR with step enable. NEXT_O exposes the value the register
// will take on the next enabled step.
module lfsr_en
    import traffic_gen_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         EN_I,
    output logic [W-1:0] STATE_O,
    output logic [W-1:0] NEXT_O
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    // One Galois step: shift right, fold feedback in when the bit shifted out is 1.
    always_comb begin
        state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end

    // Sequence register; holds unless stepped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= SEED;
        end else if (EN_I) begin
            state_q <= state_d;
        end
    end

    assign STATE_O = state_q;
    assign NEXT_O  = state_d;

endmodule

// File: rtl/traffic_gen.sv
// AXI-Stream traffic generator: emits NUM_PACKETS packets of PKT_LEN
// pseudo-random beats per START, and counts beats/packets on a sink port.
module traffic_gen
    import traffic_gen_pkg::*;
#(
    parameter int                TDATAW      = 32,
    parameter int                TDESTW      = 4,
    parameter int                TIDW        = 2,
    parameter int                LFSR_W      = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_W'(1),
    parameter int                PKT_LEN     = 4,
    parameter int                NUM_PACKETS = 16,
    parameter int                NUM_DEST    = 4,
    parameter int                SRC_ID      = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [1:0]        MODE,
    input  logic [TDESTW-1:0] FIXED_DEST,
    output logic              BUSY,
    output logic              DONE,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TIDW-1:0]   AXIS_S_TID,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TIDW-1:0]   AXIS_M_TID,
    output logic [TDESTW-1:0] AXIS_M_TDEST,
    output logic [15:0]       RX_BEATS,
    output logic [15:0]       RX_PKTS
);

    localparam int                BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int                PKT_W     = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
    localparam logic [PKT_W-1:0]  LAST_PKT  = PKT_W'(NUM_PACKETS - 1);
    localparam logic [TDESTW-1:0] DEST_MAX  = TDESTW'(NUM_DEST - 1);
    localparam logic [31:0]       DEST_MASK = 32'(NUM_DEST - 1);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [PKT_W-1:0]    pkt_q, pkt_d;
    logic [TDESTW-1:0]   dest_q, dest_d;
    logic [15:0]         rx_beats_q, rx_beats_d;
    logic [15:0]         rx_pkts_q, rx_pkts_d;
    logic                tready_q;
    logic [LFSR_W-1:0]   lfsr_cur, lfsr_nxt;
    logic                busy, fin;
    logic                start_run, m_hs, m_last, run_end, s_hs;
    logic                unused_s;

    // Destination for the packet about to start. Round-robin restarts at 0
    // on the first packet of a run; random mode takes the LFSR value that
    // will be the packet's first data beat.
    function automatic logic [TDESTW-1:0] pick_dest(
        input logic [1:0]        mode,
        input logic [TDESTW-1:0] fixed,
        input logic [TDESTW-1:0] prev,
        input logic              first,
        input logic [LFSR_W-1:0] rnd
    );
        logic [TDESTW-1:0] d;
        case (mode)
            MODE_RR:   d = (first || prev == DEST_MAX) ? '0 : prev + TDESTW'(1);
            MODE_RAND: d = TDESTW'(32'(rnd) & DEST_MASK);
            MODE_FIXED, MODE_FIXED_ALT: d = fixed;
            default:   d = fixed;
        endcase
        return d;
    endfunction

    assign start_run = (state_q == ST_IDLE) && START;
    assign m_last    = busy && (beat_q == LAST_BEAT);
    assign m_hs      = busy && AXIS_M_TREADY;
    assign run_end   = m_hs && m_last && (pkt_q == LAST_PKT);
    assign s_hs      = AXIS_S_TVALID && tready_q;

    lfsr_en #(
        .W    (LFSR_W),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .EN_I    (m_hs),
        .STATE_O (lfsr_cur),
        .NEXT_O  (lfsr_nxt)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: START only matters in IDLE, FIN always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (START)   state_d = ST_SEND;
            ST_SEND: if (run_end) state_d = ST_FIN;
            ST_FIN:               state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: busy while sending, done pulse in the single FIN cycle.
    always_comb begin
        busy = 1'b0;
        fin  = 1'b0;
        case (state_q)
            ST_SEND: busy = 1'b1;
            ST_FIN:  fin  = 1'b1;
            default: ;
        endcase
    end

    // Beat/packet/destination next state; a stalled beat leaves all three untouched.
    always_comb begin
        beat_d = beat_q;
        pkt_d  = pkt_q;
        dest_d = dest_q;
        if (start_run) begin
            beat_d = '0;
            pkt_d  = '0;
            dest_d = pick_dest(MODE, FIXED_DEST, dest_q, 1'b1, lfsr_cur);
        end else if (m_hs) begin
            if (m_last) begin
                beat_d = '0;
                pkt_d  = pkt_q + PKT_W'(1);
                dest_d = pick_dest(MODE, FIXED_DEST, dest_q, 1'b0, lfsr_nxt);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    // Sink counters; a run start clears them even if a beat lands that cycle.
    always_comb begin
        rx_beats_d = rx_beats_q;
        rx_pkts_d  = rx_pkts_q;
        if (start_run) begin
            rx_beats_d = '0;
            rx_pkts_d  = '0;
        end else if (s_hs) begin
            rx_beats_d = rx_beats_q + 16'd1;
            if (AXIS_S_TLAST) rx_pkts_d = rx_pkts_q + 16'd1;
        end
    end

    // Datapath and sink registers; sink becomes ready the first clock after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            beat_q     <= '0;
            pkt_q      <= '0;
            dest_q     <= '0;
            rx_beats_q <= '0;
            rx_pkts_q  <= '0;
            tready_q   <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            pkt_q      <= pkt_d;
            dest_q     <= dest_d;
            rx_beats_q <= rx_beats_d;
            rx_pkts_q  <= rx_pkts_d;
            tready_q   <= 1'b1;
        end
    end

    assign BUSY          = busy;
    assign DONE          = fin;
    assign AXIS_M_TVALID = busy;
    assign AXIS_M_TDATA  = busy ? TDATAW'(lfsr_cur) : '0;
    assign AXIS_M_TLAST  = m_last;
    assign AXIS_M_TID    = TIDW'(SRC_ID);
    assign AXIS_M_TDEST  = dest_q;
    assign AXIS_S_TREADY = tready_q;
    assign RX_BEATS      = rx_beats_q;
    assign RX_PKTS       = rx_pkts_q;

    // Sink payload is accepted but never inspected.
    assign unused_s = ^{AXIS_S_TDATA, AXIS_S_TID, AXIS_S_TDEST};

endmodule
